wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
// - Writeback stage of the pipelined core; the write-side driver of the register file (produces rd/wdata/regwrite).
// - Accepts retiring instructions from MEM over a valid/ready handshake, waits for load data, aligns and extends it.
// - Selects the writeback source, suppresses x0 writes and counts retired instructions.
// PARAMETERS
// - XLEN   32  datapath / register width
// - CNT_W  64  width of the retired-instruction counter
// PORTS
// - clk            in   1      clock
// - rst            in   1      reset; synchronous, active-low
// - mem_valid      in   1      MEM stage presents an instruction
// - mem_ready      out  1      WB can accept (combinational from state)
// - mem_rd         in   5      destination register
// - mem_regwrite   in   1      instruction writes rd
// - mem_wbsel      in   2      00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
// - mem_alu_result in   XLEN   ALU result; [1:0] are the load byte offset
// - mem_pc_plus4   in   XLEN   link value for JAL/JALR
// - mem_funct3     in   3      load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
// - dmem_rvalid    in   1      data memory read response valid
// - dmem_rdata     in   XLEN   data memory read word
// - rd             out  5      register file write address
// - wdata          out  XLEN   register file write data
// - regwrite       out  1      register file write enable (1-cycle pulse)
// - instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
// - Reset (rst==0 at posedge): state IDLE; rd, wdata, regwrite, instret = 0; captured fields cleared.
// - FSM states IDLE, WAIT_LOAD, COMMIT. mem_ready = 1 in IDLE and COMMIT, 0 in WAIT_LOAD.
// - Accept = mem_valid && mem_ready. On accept: capture rd, regwrite, wbsel, funct3, offset, operands.
//   - wbsel==01 -> WAIT_LOAD; otherwise -> COMMIT.
// - Without an accept: IDLE stays IDLE; COMMIT returns to IDLE.
// - WAIT_LOAD: hold until dmem_rvalid==1; capture dmem_rdata; -> COMMIT. dmem_rvalid ignored in IDLE/COMMIT.
// - COMMIT (one cycle per instruction):
//   - regwrite = captured_regwrite && rd!=0; rd/wdata driven from captured fields; instret += 1 (wraps at 2^CNT_W).
//   - An x0 destination or regwrite=0 still retires (instret increments) but produces no write.
// - Latency: non-load accepted cycle N -> write pulse cycle N+1; load -> pulse 1 cycle after dmem_rvalid.
// - Throughput: back-to-back non-loads, one per cycle (accept in COMMIT chains to COMMIT/WAIT_LOAD).
// - Load extraction: byte = rdata >> 8*offset[1:0]; half = rdata >> 16*offset[1].
//   - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW and undefined funct3 pass the full word.
//   - Misalignment is not checked here.
// - rd and wdata hold their last values outside COMMIT; only regwrite pulses.
// - Reset mid-WAIT_LOAD: instruction dropped, no write, no count; a later stray dmem_rvalid is ignored.
// CONFIGURATION
// - WB_FORWARD_EN defined: adds outputs fwd_valid(1), fwd_rd(5), fwd_data(XLEN).
//   - These mirror regwrite/rd/wdata in the COMMIT cycle for ID/EX bypass; fwd_valid resets to 0.
// - WB_FORWARD_EN undefined: these ports and their logic are absent; behaviour otherwise identical.
// STRUCTURE
// - Package yarc_wb_pkg: wbsel_e (WB_ALU, WB_LOAD, WB_PC4); LOAD_* funct3 constants; wb_state_e.
// - Sub-module load_align: combinational rdata/offset/funct3 -> extended XLEN value, instantiated once.
// TESTING
// - ALU op rd=5, alu=0x1234 accepted cycle N -> regwrite=1, rd=5, wdata=0x1234 at N+1; instret=1.
// - LB offset 3, rdata=0x80FF_FF00, rvalid 2 cycles later -> mem_ready=0 while waiting; wdata=0xFFFF_FF80.
// - LHU offset 2, rdata=0xBEEF_0000 -> wdata=0x0000_BEEF; LW -> full word.
// - JAL rd=0, pc+4=0x104 -> regwrite stays 0, instret increments.
// - Three back-to-back ALU ops -> three consecutive write pulses; mem_ready stays 1.
// - rst=0 during WAIT_LOAD, then rvalid pulse -> no write pulse, instret=0, state IDLE.

Source files
------------

// File: rtl/yarc_wb_pkg.sv
// Shared types and constants for the writeback stage: source select,
// load size/sign encodings and FSM state encoding.
package yarc_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wbsel_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_LOAD = 2'b01,
        ST_COMMIT    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of the
// read word and sign- or zero-extends it according to funct3.
module load_align
    import yarc_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            LOAD_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LOAD_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LOAD_LW:  o_data = i_rdata;
            LOAD_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            LOAD_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions from MEM, waits for load
// data, drives the register-file write port and counts retirements.
// Optional bypass outputs are enabled by defining WB_FORWARD_EN.
module wb_stage
    import yarc_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [1:0]       mem_wbsel,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [2:0]       mem_funct3,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  wdata,
    output logic             regwrite,
    output logic [CNT_W-1:0] instret
`ifdef WB_FORWARD_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data
`endif
);

    wb_state_e       r_state;
    wb_state_e       w_next;
    logic            w_accept;
    logic            w_commit_direct;
    logic            w_commit_load;

    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic [2:0]      r_funct3;
    logic [1:0]      r_offset;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_direct_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        mem_ready       = 1'b0;
        w_accept        = 1'b0;
        w_commit_direct = 1'b0;
        w_commit_load   = 1'b0;
        case (r_state)
            ST_IDLE, ST_COMMIT: begin
                mem_ready = 1'b1;
                w_accept  = mem_valid;
                if (mem_valid) begin
                    if (mem_wbsel == WB_LOAD) begin
                        w_next = ST_WAIT_LOAD;
                    end else begin
                        w_next          = ST_COMMIT;
                        w_commit_direct = 1'b1;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    w_next        = ST_COMMIT;
                    w_commit_load = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Reserved select 11 falls through to the ALU result.
    assign w_direct_data = (mem_wbsel == WB_PC4) ? mem_pc_plus4 : mem_alu_result;

    // Output registers are loaded on the edge entering COMMIT so the write
    // pulse, address, data and updated count all appear in the COMMIT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_funct3   <= '0;
            r_offset   <= '0;
            rd         <= '0;
            wdata      <= '0;
            regwrite   <= 1'b0;
            instret    <= '0;
        end else begin
            regwrite <= 1'b0;
            if (w_accept) begin
                r_rd       <= mem_rd;
                r_regwrite <= mem_regwrite;
                r_funct3   <= mem_funct3;
                r_offset   <= mem_alu_result[1:0];
            end
            if (w_commit_direct) begin
                rd       <= mem_rd;
                wdata    <= w_direct_data;
                regwrite <= mem_regwrite && (mem_rd != 5'd0);
                instret  <= instret + CNT_W'(1);
            end else if (w_commit_load) begin
                rd       <= r_rd;
                wdata    <= w_load_data;
                regwrite <= r_regwrite && (r_rd != 5'd0);
                instret  <= instret + CNT_W'(1);
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = regwrite;
    assign fwd_rd    = rd;
    assign fwd_data  = wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// instruction streams compared against a behavioural writeback model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [1:0]  mem_wbsel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus4;
    logic [2:0]  mem_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        regwrite;
    logic [63:0] instret;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    longint      exp_instret = 0;
    logic [4:0]  exp_rd      = '0;
    logic [31:0] exp_wdata   = '0;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_wbsel      (mem_wbsel),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_funct3     (mem_funct3),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rd             (rd),
        .wdata          (wdata),
        .regwrite       (regwrite),
        .instret        (instret)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural meaning of a retired instruction's write value.
    function automatic logic [31:0] model_wdata(input logic [1:0] ws, input logic [2:0] f3,
                                                input logic [31:0] alu, input logic [31:0] pc4,
                                                input logic [31:0] rdata);
        int     off;
        longint b;
        longint h;
        off = int'(alu[1:0]);
        b   = longint'(rdata >> (8 * off)) % 256;
        h   = longint'(rdata >> (16 * (off / 2))) % 65536;
        if (ws == 2'b10) return pc4;
        if (ws != 2'b01) return alu;
        case (f3)
            3'b000:  return 32'((b >= 128) ? b - 256 : b);
            3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return rdata;
        endcase
    endfunction

    task automatic check_commit(input string tag, input logic [4:0] rdv, input logic rw,
                                input logic [31:0] expw);
        exp_instret++;
        exp_rd    = rdv;
        exp_wdata = expw;
        chk({tag, "_we"},   64'(regwrite), 64'(rw && (rdv != 5'd0)));
        chk({tag, "_rd"},   64'(rd),       64'(exp_rd));
        chk({tag, "_wd"},   64'(wdata),    64'(exp_wdata));
        chk({tag, "_cnt"},  instret,       64'(exp_instret));
        chk({tag, "_rdy"},  64'(mem_ready), 64'd1);
`ifdef WB_FORWARD_EN
        chk({tag, "_fwdv"}, 64'(fwd_valid), 64'(rw && (rdv != 5'd0)));
        chk({tag, "_fwdd"}, 64'(fwd_data),  64'(exp_wdata));
`endif
    endtask

    // Starts and ends just after a falling edge; leaves the DUT in COMMIT.
    task automatic run_instr(input string tag, input logic [4:0] rdv, input logic rw,
                             input logic [1:0] ws, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] pc4,
                             input logic [31:0] rdata, input int lat);
        mem_valid      = 1'b1;
        mem_rd         = rdv;
        mem_regwrite   = rw;
        mem_wbsel      = ws;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_pc_plus4   = pc4;
        dmem_rdata     = $urandom;
        @(negedge clk);
        mem_valid      = 1'b0;
        mem_rd         = 5'($urandom);
        mem_alu_result = $urandom;
        if (ws == 2'b01) begin
            for (int i = 0; i < lat; i++) begin
                chk({tag, "_wait_rdy"}, 64'(mem_ready), 64'd0);
                chk({tag, "_wait_we"},  64'(regwrite),  64'd0);
                @(negedge clk);
            end
            chk({tag, "_wait_rdy"}, 64'(mem_ready), 64'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
        end
        check_commit(tag, rdv, rw, model_wdata(ws, f3, alu, pc4, rdata));
    endtask

    // Idle cycles with stray read responses: nothing written, values held.
    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            dmem_rvalid = 1'($urandom);
            dmem_rdata  = $urandom;
            @(negedge clk);
            chk({tag, "_idle_we"},  64'(regwrite), 64'd0);
            chk({tag, "_idle_rd"},  64'(rd),       64'(exp_rd));
            chk({tag, "_idle_wd"},  64'(wdata),    64'(exp_wdata));
            chk({tag, "_idle_cnt"}, instret,       64'(exp_instret));
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [4:0]  b2b_rd  [3];
        logic [31:0] b2b_alu [3];
        logic [1:0]  ws;
        logic [2:0]  f3;
        logic [31:0] alu;

        rst = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; mem_wbsel = '0;
        mem_alu_result = '0; mem_pc_plus4 = '0; mem_funct3 = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_we",  64'(regwrite),  64'd0);
        chk("rst_rd",  64'(rd),        64'd0);
        chk("rst_wd",  64'(wdata),     64'd0);
        chk("rst_cnt", instret,        64'd0);
        chk("rst_rdy", 64'(mem_ready), 64'd1);
        rst = 1'b1;

        run_instr("alu", 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 0);
        idle_cycles("alu", 1);
        run_instr("lb", 5'd7, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 2);
        chk("lb_val", 64'(wdata), 64'hFFFF_FF80);
        run_instr("lhu", 5'd8, 1'b1, 2'b01, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1);
        chk("lhu_val", 64'(wdata), 64'h0000_BEEF);
        run_instr("lw", 5'd9, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0);
        chk("lw_val", 64'(wdata), 64'hCAFE_F00D);
        run_instr("jal0", 5'd0, 1'b1, 2'b10, 3'b000, 32'h55, 32'h104, 32'h0, 0);
        chk("jal0_wd", 64'(wdata), 64'h104);
        run_instr("rsvd", 5'd3, 1'b1, 2'b11, 3'b000, 32'h7777, 32'h999, 32'h0, 0);
        idle_cycles("pre_b2b", 2);

        b2b_rd  = '{5'd1, 5'd2, 5'd3};
        b2b_alu = '{32'hA1, 32'hB2, 32'hC3};
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = b2b_rd[i]; mem_regwrite = 1'b1;
            mem_wbsel = 2'b00; mem_alu_result = b2b_alu[i];
            @(negedge clk);
            check_commit("b2b", b2b_rd[i], 1'b1, b2b_alu[i]);
        end
        mem_valid = 1'b0;
        idle_cycles("post_b2b", 1);

        for (int n = 0; n < 60; n++) begin
            ws  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            alu = $urandom;
            run_instr("rnd", 5'($urandom), 1'($urandom), ws, f3, alu, $urandom, $urandom,
                      int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle_cycles("rnd", int'($urandom_range(1, 2)));
        end

        mem_valid = 1'b1; mem_rd = 5'd12; mem_regwrite = 1'b1; mem_wbsel = 2'b01;
        mem_funct3 = 3'b010; mem_alu_result = 32'h40;
        @(negedge clk);
        mem_valid = 1'b0;
        chk("rstw_rdy", 64'(mem_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_instret = 0; exp_rd = '0; exp_wdata = '0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rstw_we",  64'(regwrite),  64'd0);
        chk("rstw_cnt", instret,        64'd0);
        chk("rstw_rdy", 64'(mem_ready), 64'd1);
        chk("rstw_wd",  64'(wdata),     64'd0);
        idle_cycles("rstw", 1);
        run_instr("post_rst", 5'd4, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
        idle_cycles("end", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
